// File: rtl/griffin_gi_if.sv
// griffin_gi_if: operand/result handshake bundle for the Griffin g_i stage.
interface griffin_gi_if #(parameter int N_BITS = 254);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] x_i;
    logic [N_BITS-1:0] l_i;
    logic [N_BITS-1:0] alpha;
    logic [N_BITS-1:0] beta;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] y_i;
    modport master (output in_valid, x_i, l_i, alpha, beta, out_ready,
                    input  in_ready, out_valid, y_i);
    modport slave  (input  in_valid, x_i, l_i, alpha, beta, out_ready,
                    output in_ready, out_valid, y_i);
endinterface

// File: rtl/griffin_gi_stage.sv
// griffin_gi_stage: y = x*(l*(l+alpha)+beta) mod p using one time-shared
// modular multiplier with a fixed MULT_LAT-edge pipeline.
module galois_mult_254 #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                MULT_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic [N_BITS-1:0] p
);
    logic [N_BITS-1:0] mod_prod;
    logic [N_BITS-1:0] pipe_d [MULT_LAT];
    logic [N_BITS-1:0] pipe_q [MULT_LAT];

    always_comb begin
        mod_prod  = N_BITS'(({{N_BITS{1'b0}}, a} * {{N_BITS{1'b0}}, b}) % {{N_BITS{1'b0}}, PRIME_MODULUS});
        pipe_d[0] = mod_prod;
        for (int k = 1; k < MULT_LAT; k++) pipe_d[k] = pipe_q[k-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MULT_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign p = pipe_q[MULT_LAT-1];
endmodule

module griffin_gi_stage #(
    parameter int                N_BITS        = 254,
    parameter logic [N_BITS-1:0] PRIME_MODULUS = 254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001,
    parameter int                MULT_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    griffin_gi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;
    localparam int CW = $clog2(MULT_LAT + 1) + 1;
    localparam logic [N_BITS:0] P_EXT = {1'b0, PRIME_MODULUS};

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_BITS-1:0] x_q, x_d, l_q, l_d, s_q, s_d, b_q, b_d, t_q, t_d, y_q, y_d;
    logic [N_BITS-1:0] mul_a, mul_b, prod;
    logic [N_BITS:0]   ls_sum, pb_sum;
    logic              cnt_done;

    galois_mult_254 #(
        .N_BITS(N_BITS), .PRIME_MODULUS(PRIME_MODULUS), .MULT_LAT(MULT_LAT)
    ) u_mult (
        .clk(clk), .rst_n(rst_n), .a(mul_a), .b(mul_b), .p(prod)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            l_q     <= '0;
            s_q     <= '0;
            b_q     <= '0;
            t_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            l_q     <= l_d;
            s_q     <= s_d;
            b_q     <= b_d;
            t_q     <= t_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        ls_sum   = {1'b0, bus.l_i} + {1'b0, bus.alpha};
        pb_sum   = {1'b0, prod} + {1'b0, b_q};
        cnt_done = cnt_q == CW'(MULT_LAT);
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        l_d      = l_q;
        s_d      = s_q;
        b_d      = b_q;
        t_d      = t_q;
        y_d      = y_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                x_d     = bus.x_i;
                l_d     = bus.l_i;
                s_d     = ls_sum >= P_EXT ? N_BITS'(ls_sum - P_EXT) : ls_sum[N_BITS-1:0];
                b_d     = bus.beta;
                state_d = MUL1;
            end
            // The counter reaching MULT_LAT means the pipeline already holds this phase's product.
            MUL1: begin
                cnt_d = cnt_done ? '0 : cnt_q + 1'b1;
                if (cnt_done) begin
                    t_d     = pb_sum >= P_EXT ? N_BITS'(pb_sum - P_EXT) : pb_sum[N_BITS-1:0];
                    state_d = MUL2;
                end
            end
            MUL2: begin
                cnt_d = cnt_done ? '0 : cnt_q + 1'b1;
                if (cnt_done) begin
                    y_d     = prod;
                    state_d = DONE;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = state_q == IDLE;
        bus.out_valid = state_q == DONE;
        bus.y_i       = y_q;
        mul_a         = state_q == MUL1 ? l_q : t_q;
        mul_b         = state_q == MUL1 ? s_q : x_q;
    end
endmodule

// File: tb/tb_griffin_gi_stage.sv
// tb_griffin_gi_stage: drives two small-field instances (MULT_LAT 1 and 3) in lockstep
// and compares them against a plain modular-arithmetic reference.
module tb_griffin_gi_stage;
    localparam int              NB = 8;
    localparam logic [NB-1:0]   PM = 8'd251;
    localparam int              P  = 251;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [NB-1:0] x_r = '0, l_r = '0, a_r = '0, b_r = '0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    griffin_gi_if #(.N_BITS(NB)) if1 ();
    griffin_gi_if #(.N_BITS(NB)) if3 ();

    assign if1.in_valid = in_valid;
    assign if1.out_ready = out_ready;
    assign if1.x_i = x_r;
    assign if1.l_i = l_r;
    assign if1.alpha = a_r;
    assign if1.beta = b_r;
    assign if3.in_valid = in_valid;
    assign if3.out_ready = out_ready;
    assign if3.x_i = x_r;
    assign if3.l_i = l_r;
    assign if3.alpha = a_r;
    assign if3.beta = b_r;

    griffin_gi_stage #(.N_BITS(NB), .PRIME_MODULUS(PM), .MULT_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    griffin_gi_stage #(.N_BITS(NB), .PRIME_MODULUS(PM), .MULT_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    function automatic int ref_y(input int x, input int l, input int a, input int b);
        return (x * ((l * l + a * l + b) % P)) % P;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int l, input int a, input int b);
        x_r = NB'(x);
        l_r = NB'(l);
        a_r = NB'(a);
        b_r = NB'(b);
    endtask

    task automatic scramble();
        drive($urandom_range(0, P - 1), $urandom_range(0, P - 1),
              $urandom_range(0, P - 1), $urandom_range(0, P - 1));
    endtask

    // Called at the negedge right after the accept edge; inputs are garbled to prove sampling.
    task automatic finish_op(input int e);
        int lat1 = -1, lat3 = -1;
        logic [NB-1:0] y1 = '0, y3 = '0;
        in_valid = 1'b0;
        scramble();
        for (int n = 1; n <= 40 && (lat1 < 0 || lat3 < 0); n++) begin
            @(negedge clk);
            if (lat1 < 0 && if1.out_valid) begin lat1 = n; y1 = if1.y_i; end
            if (lat3 < 0 && if3.out_valid) begin lat3 = n; y3 = if3.y_i; end
        end
        chk("lat1", lat1, 4);
        chk("lat3", lat3, 8);
        chk("y1", 32'(y1), e);
        chk("y3", 32'(y3), e);
        if (out_ready) begin
            @(negedge clk);
            chk("rdy1_after", 32'(if1.in_ready), 1);
            chk("rdy3_after", 32'(if3.in_ready), 1);
        end
    endtask

    task automatic op(input int x, input int l, input int a, input int b);
        @(negedge clk);
        chk("rdy1_before", 32'(if1.in_ready), 1);
        chk("rdy3_before", 32'(if3.in_ready), 1);
        drive(x, l, a, b);
        in_valid = 1'b1;
        @(negedge clk);
        finish_op(ref_y(x, l, a, b));
    endtask

    initial begin
        int e;
        int seen;
        #1;
        chk("rst_rdy1", 32'(if1.in_ready), 1);
        chk("rst_ov1", 32'(if1.out_valid), 0);
        chk("rst_y1", 32'(if1.y_i), 0);
        chk("rst_rdy3", 32'(if3.in_ready), 1);
        chk("rst_ov3", 32'(if3.out_valid), 0);
        chk("rst_y3", 32'(if3.y_i), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(2, 3, 1, 1);
        op(7, 250, 2, 1);
        op(5, 250, 0, 0);
        op(3, 16, 0, 250);
        op(250, 250, 250, 250);
        for (int i = 0; i < 16; i++)
            op($urandom_range(0, P - 1), $urandom_range(0, P - 1),
               $urandom_range(0, P - 1), $urandom_range(0, P - 1));

        out_ready = 1'b0;
        op(9, 4, 7, 3);
        e = ref_y(9, 4, 7, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            scramble();
            @(negedge clk);
            chk("stall_ov1", 32'(if1.out_valid), 1);
            chk("stall_ov3", 32'(if3.out_valid), 1);
            chk("stall_y1", 32'(if1.y_i), e);
            chk("stall_y3", 32'(if3.y_i), e);
            chk("stall_rdy1", 32'(if1.in_ready), 0);
            chk("stall_rdy3", 32'(if3.in_ready), 0);
        end
        // Both handshakes high in DONE: only the output side completes on this edge.
        drive(6, 7, 8, 9);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rel_rdy1", 32'(if1.in_ready), 1);
        chk("rel_rdy3", 32'(if3.in_ready), 1);
        chk("rel_ov1", 32'(if1.out_valid), 0);
        chk("rel_ov3", 32'(if3.out_valid), 0);
        @(negedge clk);
        finish_op(ref_y(6, 7, 8, 9));

        @(negedge clk);
        drive(2, 3, 1, 1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ov1", 32'(if1.out_valid), 0);
        chk("mid_rst_y1", 32'(if1.y_i), 0);
        chk("mid_rst_rdy1", 32'(if1.in_ready), 1);
        chk("mid_rst_ov3", 32'(if3.out_valid), 0);
        chk("mid_rst_y3", 32'(if3.y_i), 0);
        chk("mid_rst_rdy3", 32'(if3.in_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen += int'(if1.out_valid) + int'(if3.out_valid);
        end
        chk("no_ghost_valid", seen, 0);
        op(2, 3, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
